cla_sat_addsub_pipe: RTL

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with signed overflow detection and selectable per-operation saturation. Successor to the 16-bit combinational CLA saturating adder, for use as a shared ALU arithmetic unit. Operands enter through a valid/ready handshake and results leave through one. A sticky overflow flag is kept for status reporting.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_group4.sv | 32 +++
 rtl/cla_sat_addsub_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined CLA add/sub unit.
// Provides the lookahead group width and the signed saturation limits.
package cla_pkg;

    localparam int GROUP_W = 4;

    // Largest positive two's complement value of the given width.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of the given width.
    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
// Ports: a, b, cin in; sum, group propagate p, group generate g out.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               p,
    output logic               g
);

    logic [GROUP_W-1:0] pb;
    logic [GROUP_W-1:0] gb;
    logic [GROUP_W-1:0] c;

    always_comb begin
        pb   = a ^ b;
        gb   = a & b;
        c[0] = cin;
        c[1] = gb[0] | (pb[0] & cin);
        c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
        c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
             | (pb[2] & pb[1] & pb[0] & cin);
        sum  = pb ^ c;
        p    = &pb;
        g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);
    end

endmodule

// File: rtl/cla_sat_addsub_pipe.sv
// Two-stage pipelined CLA adder/subtractor with signed overflow,
// optional saturation, valid/ready handshakes and a sticky overflow flag.
// Ports: clk, rst (async, active high); in_valid/in_ready, a, b, sub, sat;
// out_valid/out_ready, result, ovf, carry_out; sticky_ovf, clr_sticky.
module cla_sat_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             carry_out,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    localparam int GROUPS = WIDTH / GROUP_W;
    localparam logic [63:0] MAX64 = sat_max(WIDTH);
    localparam logic [63:0] MIN64 = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_HI = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_LO = MIN64[WIDTH-1:0];

    logic adv1, adv2;

    // Stage 1 combinational: operand inversion and per-group lookahead.
    logic [WIDTH-1:0]  nb;
    logic [WIDTH-1:0]  sum0_d, sum1_d;
    logic [GROUPS-1:0] p_d, g_d;

    assign nb = sub ? ~b : b;

    // Group sum for cin=1 is the cin=0 sum plus one; P/G do not depend on cin.
    for (genvar i = 0; i < GROUPS; i++) begin : g_grp
        cla_group4 u_grp (
            .a   (a[i*GROUP_W +: GROUP_W]),
            .b   (nb[i*GROUP_W +: GROUP_W]),
            .cin (1'b0),
            .sum (sum0_d[i*GROUP_W +: GROUP_W]),
            .p   (p_d[i]),
            .g   (g_d[i])
        );
        assign sum1_d[i*GROUP_W +: GROUP_W] =
            sum0_d[i*GROUP_W +: GROUP_W] + 4'd1;
    end

    // Stage 1 registers.
    logic              s1_valid, s1_a_msb, s1_nb_msb, s1_cin, s1_sat;
    logic [GROUPS-1:0] s1_p, s1_g;
    logic [WIDTH-1:0]  s1_sum0, s1_sum1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a_msb  <= 1'b0;
            s1_nb_msb <= 1'b0;
            s1_cin    <= 1'b0;
            s1_sat    <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
        end else if (adv1) begin
            s1_valid  <= in_valid;
            s1_a_msb  <= a[WIDTH-1];
            s1_nb_msb <= nb[WIDTH-1];
            s1_cin    <= sub;
            s1_sat    <= sat;
            s1_p      <= p_d;
            s1_g      <= g_d;
            s1_sum0   <= sum0_d;
            s1_sum1   <= sum1_d;
        end
    end

    // Stage 2 combinational: expanded group carries, select, saturate.
    logic [GROUPS:0]  carry;
    logic [WIDTH-1:0] sum, res_d;
    logic             acc, term, pos_ovf, neg_ovf;

    always_comb begin
        carry = '0;
        acc   = 1'b0;
        term  = 1'b0;
        sum   = '0;
        // C(i) = cin&P(0..i-1) | OR_j G(j)&P(j+1..i-1), no ripple chain.
        for (int i = 0; i <= GROUPS; i++) begin
            acc = s1_cin;
            for (int k = 0; k < i; k++)
                acc = acc & s1_p[k];
            for (int j = 0; j < i; j++) begin
                term = s1_g[j];
                for (int k = j + 1; k < i; k++)
                    term = term & s1_p[k];
                acc = acc | term;
            end
            carry[i] = acc;
        end
        for (int i = 0; i < GROUPS; i++)
            sum[i*GROUP_W +: GROUP_W] = carry[i]
                ? s1_sum1[i*GROUP_W +: GROUP_W]
                : s1_sum0[i*GROUP_W +: GROUP_W];
        pos_ovf = ~s1_a_msb & ~s1_nb_msb & sum[WIDTH-1];
        neg_ovf = s1_a_msb & s1_nb_msb & ~sum[WIDTH-1];
        res_d   = sum;
        if (s1_sat && pos_ovf)
            res_d = SAT_HI;
        else if (s1_sat && neg_ovf)
            res_d = SAT_LO;
    end

    // Stage 2 registers and sticky status.
    logic s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            carry_out <= 1'b0;
        end else if (adv2) begin
            s2_valid  <= s1_valid;
            result    <= res_d;
            ovf       <= pos_ovf | neg_ovf;
            carry_out <= carry[GROUPS];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_ovf <= 1'b0;
        else if (s2_valid && out_ready && ovf)
            sticky_ovf <= 1'b1;
        else if (clr_sticky)
            sticky_ovf <= 1'b0;
    end

    assign adv2      = ~s2_valid | out_ready;
    assign adv1      = ~s1_valid | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

endmodule
